// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory and its program loader.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // Index width for a DEPTH-entry array; never narrower than one bit.
    function automatic int clog2(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port DEPTH x DATA_W storage: synchronous write, registered read.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset; it maps onto RAM macros and the loader's CLEAR pass initialises it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with CLEAR/LOAD/RUN sequencing, a valid/ready program load
// port and one-cycle registered fetches with address translation and fault flagging.
module imem_loader
    import imem_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                DEPTH          = 32,
    parameter int                PC_W           = 32,
    parameter bit                BYTE_ADDR      = 1'b1,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] NOP_WORD       = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [PC_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_err,
    input  logic              reload,
    output logic              mem_ready,
    input  logic              fetch_req,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_ins,
    output logic              fetch_fault
);

    localparam int     AW          = clog2(DEPTH);
    localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ld_err_q, ld_err_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_fault_q, fetch_fault_d;

    logic              ram_we, ram_re;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    logic [PC_W-1:0]   fetch_idx;
    logic              fetch_bad;
    logic              ld_in_range;

    // Range checks use the full address width so high bits can never alias into the array.
    assign fetch_idx   = BYTE_ADDR ? (fetch_pc >> 2) : fetch_pc;
    assign fetch_bad   = (fetch_idx >= PC_W'(DEPTH)) || (BYTE_ADDR && (fetch_pc[1:0] != 2'b00));
    assign ld_in_range = ld_addr < PC_W'(DEPTH);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ld_err_d      = ld_err_q;
        fetch_valid_d = 1'b0;
        fetch_fault_d = 1'b0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = NOP_WORD;

        unique case (state_q)
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = cnt_q;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    if (ld_in_range) begin
                        ram_we    = 1'b1;
                        ram_addr  = ld_addr[AW-1:0];
                        ram_wdata = ld_data;
                    end else begin
                        ld_err_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_d = ST_LOAD;
                end else if (fetch_req) begin
                    fetch_valid_d = 1'b1;
                    fetch_fault_d = fetch_bad;
                    ram_re        = !fetch_bad;
                    ram_addr      = fetch_idx[AW-1:0];
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RESET_STATE;
            cnt_q         <= '0;
            ld_err_q      <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ld_err_q      <= ld_err_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign ld_ready    = (state_q == ST_LOAD);
    assign mem_ready   = (state_q == ST_RUN);
    assign ld_err      = ld_err_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_ins   = fetch_fault_q ? NOP_WORD : ram_rdata;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table of fetches plus hand-written
// sequences for clear timing, loading, reload and mid-run reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready, ld_last, ld_err;
    logic [31:0] ld_addr, ld_data;
    logic        reload, mem_ready;
    logic        fetch_req, fetch_valid, fetch_fault;
    logic [31:0] fetch_pc, fetch_ins;

    localparam logic [31:0] NOP = 32'h0000_0000;

    imem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_err      (ld_err),
        .reload      (reload),
        .mem_ready   (mem_ready),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .fetch_ins   (fetch_ins),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        logic        fault;
    } exp_t;

    vec_t vecs [12];
    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        ld_last   = 1'b0;
        reload    = 1'b0;
        fetch_req = 1'b0;
        fetch_pc  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ld_ready"},    32'(ld_ready),    32'd0);
        check({tag, ".ld_err"},      32'(ld_err),      32'd0);
        check({tag, ".mem_ready"},   32'(mem_ready),   32'd0);
        check({tag, ".fetch_valid"}, 32'(fetch_valid), 32'd0);
        check({tag, ".fetch_ins"},   fetch_ins,        32'd0);
        check({tag, ".fetch_fault"}, 32'(fetch_fault), 32'd0);
    endtask

    // Counts edges from reset release until ld_ready rises, bounded.
    task automatic wait_clear(input string tag);
        int cycles = 0;
        while (!ld_ready && cycles < 200) begin
            tick();
            cycles++;
        end
        check({tag, ".clear_cycles"}, 32'(cycles), 32'd32);
    endtask

    task automatic load_beat(input logic [31:0] addr, input logic [31:0] data, input logic last);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Issues one fetch (req stays high so consecutive calls are back-to-back) and checks its response.
    task automatic fetch_check(input string tag, input logic [31:0] pc,
                               input logic [31:0] ins, input logic fault);
        exp_t e;
        fetch_req = 1'b1;
        fetch_pc  = pc;
        exp_q.push_back('{ins: ins, fault: fault});
        tick();
        check({tag, ".valid"}, 32'(fetch_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".ins"},   fetch_ins,          e.ins);
            check({tag, ".fault"}, 32'(fetch_fault),   32'(e.fault));
        end
    endtask

    task automatic fetch_stop(input string tag);
        fetch_req = 1'b0;
        tick();
        check({tag, ".valid_drop"}, 32'(fetch_valid), 32'd0);
        check({tag, ".scoreboard_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{pc: 32'h0000_0000, ins: 32'h2008_0005, fault: 1'b0};
        vecs[1]  = '{pc: 32'h0000_0004, ins: 32'h2009_0003, fault: 1'b0};
        vecs[2]  = '{pc: 32'h0000_0008, ins: 32'h0109_5020, fault: 1'b0};
        vecs[3]  = '{pc: 32'h0000_000C, ins: 32'hAC0A_0000, fault: 1'b0};
        vecs[4]  = '{pc: 32'h0000_0080, ins: NOP,           fault: 1'b1};
        vecs[5]  = '{pc: 32'h0000_0006, ins: NOP,           fault: 1'b1};
        vecs[6]  = '{pc: 32'h0000_007C, ins: NOP,           fault: 1'b0};
        vecs[7]  = '{pc: 32'h0000_0010, ins: NOP,           fault: 1'b0};
        vecs[8]  = '{pc: 32'h0000_00A0, ins: NOP,           fault: 1'b1};
        vecs[9]  = '{pc: 32'hFFFF_FFFC, ins: NOP,           fault: 1'b1};
        vecs[10] = '{pc: 32'h0000_0101, ins: NOP,           fault: 1'b1};
        vecs[11] = '{pc: 32'h0000_0004, ins: 32'h2009_0003, fault: 1'b0};

        idle_inputs();
        rst = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");

        // Clear pass then empty image.
        rst = 1'b1;
        wait_clear("boot");
        load_beat(32'd0, 32'd0, 1'b1);
        check("empty.mem_ready", 32'(mem_ready), 32'd1);
        check("empty.ld_ready",  32'(ld_ready),  32'd0);
        fetch_check("empty0",  32'h0000_0000, NOP, 1'b0);
        fetch_check("empty31", 32'h0000_007C, NOP, 1'b0);
        fetch_stop("empty");

        // Reload the program, with one out-of-range beat and a fetch issued during LOAD.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload.ld_ready",  32'(ld_ready),  32'd1);
        check("reload.mem_ready", 32'(mem_ready), 32'd0);
        fetch_req = 1'b1;
        fetch_pc  = 32'd0;
        load_beat(32'd0, 32'h2008_0005, 1'b0);
        fetch_req = 1'b0;
        check("load.fetch_ignored", 32'(fetch_valid), 32'd0);
        load_beat(32'd1, 32'h2009_0003, 1'b0);
        load_beat(32'd2, 32'h0109_5020, 1'b0);
        check("load.ld_err_clean", 32'(ld_err), 32'd0);
        load_beat(32'd40, 32'hDEAD_BEEF, 1'b0);
        check("load.ld_err_set",    32'(ld_err),    32'd1);
        check("load.still_loading", 32'(mem_ready), 32'd0);
        load_beat(32'd3, 32'hAC0A_0000, 1'b1);
        check("load.mem_ready", 32'(mem_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            fetch_check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ins, vecs[i].fault);
        end
        fetch_stop("vecs");
        check("run.ld_err_sticky", 32'(ld_err), 32'd1);

        // reload wins over a same-cycle fetch.
        reload    = 1'b1;
        fetch_req = 1'b1;
        fetch_pc  = 32'd0;
        tick();
        reload    = 1'b0;
        fetch_req = 1'b0;
        check("reload_fetch.valid",    32'(fetch_valid), 32'd0);
        check("reload_fetch.ld_ready", 32'(ld_ready),    32'd1);
        load_beat(32'd2, 32'h1234_5678, 1'b1);
        check("reload2.mem_ready", 32'(mem_ready), 32'd1);
        fetch_check("reload2.w2", 32'h0000_0008, 32'h1234_5678, 1'b0);
        fetch_check("reload2.w0", 32'h0000_0000, 32'h2008_0005, 1'b0);
        fetch_check("reload2.w3", 32'h0000_000C, 32'hAC0A_0000, 1'b0);
        check("reload2.ld_err", 32'(ld_err), 32'd1);

        // Reset asserted while fetches are streaming.
        fetch_pc = 32'h0000_0004;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        idle_inputs();
        tick();
        rst = 1'b1;
        wait_clear("reclear");
        load_beat(32'd0, NOP, 1'b1);
        for (int w = 0; w < 32; w++) begin
            fetch_check($sformatf("cleared%0d", w), 32'(w * 4), NOP, 1'b0);
        end
        fetch_stop("cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory with an on-chip program loader, replacing the fixed 32×32 asynchronous-read instruction store. Clears its array after reset, accepts a program image over a valid/ready load port, then serves registered instruction fetches to the processor front end with byte-address translation and fault flagging. Sits between the boot/testbench loader and the fetch stage of the single-cycle and SIMD cores.

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 32, number of instruction words (≥2, power of two not required)
- PC_W, 32, width of fetch and load addresses
- BYTE_ADDR, 1, 1: fetch_pc is a byte address (word index = pc>>2); 0: fetch_pc is a word index
- CLEAR_ON_RESET, 1, 1: run CLEAR pass after reset; 0: enter LOAD directly
- NOP_WORD, 0, value written by CLEAR and returned on faulting fetch

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted when high with ld_valid
- ld_addr  in  PC_W  word index of load beat
- ld_data  in  DATA_W  instruction word to store
- ld_last  in  1  final beat of image
- ld_err  out  1  sticky: an out-of-range load beat was dropped
- reload  in  1  single-cycle request to return from RUN to LOAD
- mem_ready  out  1  high in RUN only
- fetch_req  in  1  fetch request
- fetch_pc  in  PC_W  fetch address
- fetch_valid  out  1  fetch_ins/fetch_fault valid
- fetch_ins  out  DATA_W  fetched instruction
- fetch_fault  out  1  fetch was out of range or misaligned

## Operation
- States: CLEAR, LOAD, RUN. Reset forces CLEAR (or LOAD if CLEAR_ON_RESET=0), clear counter 0.
- CLEAR: write NOP_WORD to index = counter, counter+1 per cycle; after index DEPTH-1 written → LOAD. ld_ready=0, mem_ready=0.
- LOAD: ld_ready=1. Accepted beat with ld_addr<DEPTH writes ld_data; ld_addr≥DEPTH: no write, ld_err←1. Accepted beat with ld_last → RUN next cycle (write of that beat still performed). ld_err cleared only by reset.
- RUN: mem_ready=1, ld_ready=0. fetch_req accepted every cycle. Index = BYTE_ADDR ? fetch_pc>>2 : fetch_pc (full-width compare, no truncation). Fault if index≥DEPTH or (BYTE_ADDR and fetch_pc[1:0]≠0); faulting fetch returns NOP_WORD, fetch_fault=1.
- reload in RUN → LOAD next cycle, no clear; reload priority over same-cycle fetch_req (fetch dropped, fetch_valid=0 next cycle). reload outside RUN ignored.
- fetch_req outside RUN ignored; ld_valid outside LOAD ignored.

## Timing
- Reset values: ld_ready=0, ld_err=0, mem_ready=0, fetch_valid=0, fetch_ins=0, fetch_fault=0; state CLEAR/LOAD per parameter.
- CLEAR lasts exactly DEPTH cycles after reset release; ld_ready rises on cycle DEPTH.
- Fetch latency 1 cycle: request at edge n → fetch_valid/fetch_ins/fetch_fault registered at edge n+1, held only one cycle (fetch_valid=0 when no request).
- Full throughput: back-to-back requests yield back-to-back responses.
- Load-then-fetch: write at edge n visible to fetch issued in the cycle after mem_ready rises; no read-during-write hazard exists since LOAD and RUN are exclusive.
- Reset mid-operation (any state): outputs to reset values immediately, in-flight fetch response discarded, array contents undefined until CLEAR completes.

## Structure
- Package imem_pkg: state enum (CLEAR, LOAD, RUN), default NOP constant, index-width function clog2(DEPTH).
- Sub-module imem_ram: single-port, synchronous write, synchronous read, DEPTH×DATA_W, no reset on array; imem_loader owns the FSM, counter, address translation and fault logic.

## Test plan
- Reset release, DEPTH=32 → ld_ready rises after exactly 32 cycles; fetching any word after empty load (ld_last on first beat, addr 0 data 0) returns 0x00000000.
- Load words 0..3 = 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 with ld_last on 3 → mem_ready next cycle; fetch_pc 0,4,8,12 back-to-back → those words one cycle later, fetch_fault=0 each.
- Fetch fetch_pc=0x80 (index 32) and 0x06 (misaligned) → fetch_ins=NOP_WORD, fetch_fault=1.
- Load beat ld_addr=40 → no write, ld_err=1 and stays 1 through RUN until reset.
- reload asserted with fetch_req same cycle → fetch_valid=0 next cycle, ld_ready=1; reload word 2 = 0x12345678, ld_last → fetch 8 returns 0x12345678, word 0 unchanged.
- Assert rst during back-to-back fetching → fetch_valid=0 immediately, CLEAR re-runs for DEPTH cycles, all words read NOP_WORD afterward.
